fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupling instruction buffer between the IF stage and the ID stage. Replaces the fixed chain of delay registers.
- IF pushes fetched instructions with their PCs; ID pops them in order when not frozen.
- The branch predictor's flush empties the queue on a misprediction.
- Output is registered and drives ID's instruction, PC and PC+4 inputs directly.

Parameters:
- DEPTH, 8: number of entries. Must be a power of two and at least 2.
- PTR_W, 3: pointer width, equal to log2(DEPTH).
- NOP_WORD, 32'h0000_0000: instruction word driven on a bubble.

Ports:
- CLK  in  1  clock, all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- FLUSH  in  1  misprediction flush from the branch predictor
- STALL  in  1  ID freeze request (WANT_FREEZE)
- Valid_IF  in  1  IF presents a valid instruction this cycle
- Instr1_IF  in  32  fetched instruction word
- Instr_PC_IF  in  32  PC of the fetched instruction
- Instr_PC_Plus4_IF  in  32  PC+4 of the fetched instruction
- Full  out  1  queue full; IF must hold its PC
- Instr1_OUT  out  32  instruction to ID
- Instr_PC_OUT  out  32  PC to ID
- Instr_PC_Plus4  out  32  PC+4 to ID
- Valid_OUT  out  1  output register holds a real instruction
- Count  out  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: circular buffer of DEPTH entries, each {instr, pc, pc+4}. Write pointer wp and read pointer rp are PTR_W bits wide and wrap modulo DEPTH. Count is a separate register.
- Full is combinational: Full = (Count == DEPTH). Empty = (Count == 0), internal only.
- Push = Valid_IF && !Full. Data is written at wp and wp increments.
- Pop = !STALL && !Empty. The entry at rp is loaded into the output registers, Valid_OUT is set to 1, and rp increments.
- When !STALL && Empty: outputs load Instr1_OUT=NOP_WORD, Instr_PC_OUT=0, Instr_PC_Plus4=0, Valid_OUT=0 (bubble).
- When STALL: output registers hold their values and nothing is popped. Pushes continue until Full.
- Count next value = Count + Push - Pop. Simultaneous push and pop leaves Count unchanged.
- Full is evaluated on the current Count. A push into a full queue is rejected even if a pop occurs in the same cycle; there is no write-through.
- Push into an empty queue with !STALL: the entry is stored and the output shows a bubble that cycle. There is no bypass path.
- Minimum latency: an instruction pushed at edge N appears on the outputs after edge N+1.
- FLUSH takes priority over STALL, push and pop:
  - wp=rp=0 and Count=0;
  - outputs are set to the bubble values with Valid_OUT=0;
  - any push in the same cycle is discarded.
- RESET takes priority over FLUSH. Reset values:
  - wp=0, rp=0, Count=0, Full=0;
  - Instr1_OUT=NOP_WORD, Instr_PC_OUT=0, Instr_PC_Plus4=0, Valid_OUT=0.
- RESET mid-operation discards all entries. Storage array contents need not be cleared.
- Order is strictly FIFO. Pointer wrap from DEPTH-1 to 0 must not lose or duplicate entries.
- No combinational path from Valid_IF or STALL to any output except Full. Full depends on Count only.

Test Plan:
- Reset, then push PCs 0x100, 0x104, 0x108 (instrs 0xA1, 0xA2, 0xA3) with STALL=0 -> outputs show 0x100/0xA1 one cycle after its push, then 0x104 and 0x108 in order. Valid_OUT=1 for exactly 3 cycles, Count returns to 0.
- STALL=1, push 8 consecutive instructions -> Count=8, Full=1, 9th push rejected, outputs unchanged. Release STALL -> 8 pops in order, 9th instruction absent.
- Full queue, STALL=0, Valid_IF=1 in the same cycle -> pop happens, push rejected, Count becomes 7. Next cycle the push is accepted and Count stays 7.
- 20 push/pop cycles with DEPTH=8 and staggered STALL -> PC sequence 0x200..0x24C comes out intact across two pointer wraps.
- 5 entries queued, FLUSH=1 together with Valid_IF=1 and STALL=1 -> next cycle Count=0, Valid_OUT=0, Instr1_OUT=0. The pushed entry never appears.
- RESET asserted with 3 entries queued and FLUSH=1 -> all outputs at reset values. A subsequent push of 0x300 emerges first.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: in-order IF-to-ID instruction buffer with a registered output stage, flush and freeze
module fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter int          PTR_W    = 3,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             STALL,
    input  logic             Valid_IF,
    input  logic [31:0]      Instr1_IF,
    input  logic [31:0]      Instr_PC_IF,
    input  logic [31:0]      Instr_PC_Plus4_IF,
    output logic             Full,
    output logic [31:0]      Instr1_OUT,
    output logic [31:0]      Instr_PC_OUT,
    output logic [31:0]      Instr_PC_Plus4,
    output logic             Valid_OUT,
    output logic [PTR_W:0]   Count
);
    logic [95:0]      mem [DEPTH];
    logic [PTR_W-1:0] wp, rp;
    logic             push, pop;
    assign Full = Count == (PTR_W+1)'(DEPTH);
    assign push = Valid_IF && !Full;
    assign pop  = !STALL && Count != '0;
    always_ff @(posedge CLK)
        if (push && !RESET && !FLUSH) mem[wp] <= {Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF};
    // reset and flush share one clearing path; reset only differs in that it wins when both are high
    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            wp             <= '0;
            rp             <= '0;
            Count          <= '0;
            Instr1_OUT     <= NOP_WORD;
            Instr_PC_OUT   <= '0;
            Instr_PC_Plus4 <= '0;
            Valid_OUT      <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            Count <= Count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            if (!STALL)
                {Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Valid_OUT} <= pop ? {mem[rp], 1'b1} : {NOP_WORD, 64'b0, 1'b0};
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench; driver queues expected entries, monitor checks every output cycle
module tb_fetch_queue;
    typedef struct packed {
        logic [31:0] i;
        logic [31:0] p;
        logic [31:0] p4;
    } entry_t;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1, FLUSH = 1'b0, STALL = 1'b0, Valid_IF = 1'b0;
    logic [31:0] Instr1_IF = '0, Instr_PC_IF = '0, Instr_PC_Plus4_IF = '0;
    logic        Full, Valid_OUT;
    logic [31:0] Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4;
    logic [3:0]  Count;
    entry_t      exp_q [$];
    int          pend = 0;
    int          vectors = 0, miscompares = 0;
    always #5 CLK = ~CLK;
    fetch_queue dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .STALL(STALL), .Valid_IF(Valid_IF),
        .Instr1_IF(Instr1_IF), .Instr_PC_IF(Instr_PC_IF), .Instr_PC_Plus4_IF(Instr_PC_Plus4_IF),
        .Full(Full), .Instr1_OUT(Instr1_OUT), .Instr_PC_OUT(Instr_PC_OUT),
        .Instr_PC_Plus4(Instr_PC_Plus4), .Valid_OUT(Valid_OUT), .Count(Count)
    );
    function automatic void cmp(string nm, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endfunction
    // monitor: decides what the outputs must be from the inputs seen at the edge and the scoreboard
    logic        m_s, m_f, m_r;
    int          m_n;
    entry_t      m_e;
    logic [31:0] h_i, h_p, h_p4;
    logic        h_v;
    always @(posedge CLK) begin
        m_s = STALL;
        m_f = FLUSH;
        m_r = RESET;
        m_n = exp_q.size() - pend;
        #1;
        if (m_r || m_f) begin
            cmp("clr_valid", 32'(Valid_OUT), 0);
            cmp("clr_instr", Instr1_OUT, 0);
            cmp("clr_pc", Instr_PC_OUT, 0);
            cmp("clr_pc4", Instr_PC_Plus4, 0);
        end else if (m_s) begin
            cmp("hold_valid", 32'(Valid_OUT), 32'(h_v));
            cmp("hold_instr", Instr1_OUT, h_i);
            cmp("hold_pc", Instr_PC_OUT, h_p);
            cmp("hold_pc4", Instr_PC_Plus4, h_p4);
        end else if (m_n > 0) begin
            m_e = exp_q.pop_front();
            cmp("pop_valid", 32'(Valid_OUT), 1);
            cmp("pop_instr", Instr1_OUT, m_e.i);
            cmp("pop_pc", Instr_PC_OUT, m_e.p);
            cmp("pop_pc4", Instr_PC_Plus4, m_e.p4);
        end else begin
            cmp("bubble_valid", 32'(Valid_OUT), 0);
            cmp("bubble_instr", Instr1_OUT, 0);
            cmp("bubble_pc", Instr_PC_OUT, 0);
        end
        h_v = Valid_OUT;
        h_i = Instr1_OUT;
        h_p = Instr_PC_OUT;
        h_p4 = Instr_PC_Plus4;
    end
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic st, input logic fl, input logic rs);
        logic acc;
        @(negedge CLK);
        cmp("count", 32'(Count), exp_q.size());
        cmp("full", 32'(Full), 32'(exp_q.size() == 8));
        acc = v && !fl && !rs && exp_q.size() < 8;
        Valid_IF = v;
        Instr1_IF = ins;
        Instr_PC_IF = pc;
        Instr_PC_Plus4_IF = pc + 4;
        STALL = st;
        FLUSH = fl;
        RESET = rs;
        pend = acc ? 1 : 0;
        if (acc) exp_q.push_back('{ins, pc, pc + 32'd4});
        @(posedge CLK);
        #2;
        if (fl || rs) exp_q.delete();
        pend = 0;
    endtask
    task automatic drain();
        for (int k = 0; k < 12; k++) cycle(0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (2) @(posedge CLK);
        #2;
        cmp("rst_count", 32'(Count), 0);
        cmp("rst_full", 32'(Full), 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 32'h100, 32'hA1, 0, 0, 0);
        cycle(1, 32'h104, 32'hA2, 0, 0, 0);
        cycle(1, 32'h108, 32'hA3, 0, 0, 0);
        drain();
        for (int k = 0; k < 9; k++) cycle(1, 32'h400 + 32'(4 * k), 32'hB0 + 32'(k), 1, 0, 0);
        cmp("stall_cnt8", 32'(Count), 8);
        cmp("stall_full", 32'(Full), 1);
        drain();
        for (int k = 0; k < 8; k++) cycle(1, 32'h500 + 32'(4 * k), 32'hC0 + 32'(k), 1, 0, 0);
        cycle(1, 32'h520, 32'hC8, 0, 0, 0);
        cmp("full_pop_cnt7", 32'(Count), 7);
        cycle(1, 32'h520, 32'hC8, 0, 0, 0);
        cmp("push_pop_cnt7", 32'(Count), 7);
        drain();
        for (int k = 0; k < 20; k++) cycle(1, 32'h200 + 32'(4 * k), 32'hD00 + 32'(k), logic'(k % 3 == 1), 0, 0);
        drain();
        for (int k = 0; k < 5; k++) cycle(1, 32'h600 + 32'(4 * k), 32'hE0 + 32'(k), 1, 0, 0);
        cycle(1, 32'h6FC, 32'hEF, 1, 1, 0);
        cmp("flush_cnt", 32'(Count), 0);
        cmp("flush_valid", 32'(Valid_OUT), 0);
        cmp("flush_instr", Instr1_OUT, 0);
        drain();
        for (int k = 0; k < 3; k++) cycle(1, 32'h700 + 32'(4 * k), 32'hF0 + 32'(k), 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 1);
        cmp("reset_cnt", 32'(Count), 0);
        cmp("reset_full", 32'(Full), 0);
        cycle(1, 32'h300, 32'h33, 0, 0, 0);
        drain();
        cmp("final_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
